// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the XOR-sharing arbiter.
//   state_e      : sequencer state (ST_IDLE, ST_HOLD)
//   WIDTH_DEF    : default operand width
//   NREQ_DEF     : default requester count
//   rr_next_idx  : index following a grant, wrapping modulo nreq
package xor_arb_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned NREQ_DEF  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int unsigned rr_next_idx(input int unsigned idx,
                                              input int unsigned nreq);
    return (idx + 32'd1 >= nreq) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/xor_share_arb_rr_pick.sv
// rr_pick: combinational rotating-priority select.
// Ports:
//   req        in  NREQ  request vector
//   ptr        in  IDW   index with highest priority this cycle
//   gnt        out NREQ  one-hot grant (zero when nothing requests)
//   gnt_idx    out IDW   index of the granted request
//   any_valid  out 1     at least one request present
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_valid
);

  int unsigned scan;

  // Walk ptr, ptr+1, ... modulo NREQ and keep the first hit.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any_valid = 1'b0;
    scan      = 32'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = (32'(ptr) + k) % NREQ;
      if (!any_valid && req[scan[IDW-1:0]]) begin
        any_valid              = 1'b1;
        gnt_idx                = scan[IDW-1:0];
        gnt[scan[IDW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_share_arb.sv
// xor_share_arb: round-robin arbiter sharing one registered XOR datapath
// among NREQ requesters. One operation is outstanding at a time: a grant
// in IDLE loads the result registers, which are held in HOLD until the
// consumer accepts.
// Optional feature macro: XOR_ARB_PARITY_EN adds rsp_parity.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    in  NREQ        per-requester valid
//   req_ready    out NREQ        per-requester accept (one-hot or zero)
//   req_a/req_b  in  NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid    out 1           result valid
//   rsp_ready    in  1           consumer accept
//   rsp_data     out WIDTH       registered a ^ b
//   rsp_id       out IDW         requester that produced rsp_data
//   rsp_parity   out 1           even parity of rsp_data (macro only)
module xor_share_arb
  import xor_arb_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned NREQ  = NREQ_DEF,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
`ifdef XOR_ARB_PARITY_EN
  ,
  output logic                  rsp_parity
`endif
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_valid;
  logic [WIDTH-1:0] sel_xor;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .any_valid (any_valid)
  );

  // Grant is one-hot, so an AND-OR mux selects the winner's operands.
  always_comb begin
    sel_xor = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_xor = sel_xor | (req_a[i*WIDTH +: WIDTH] ^ req_b[i*WIDTH +: WIDTH]);
      end
    end
  end

  // rst_n gating keeps an accept from being signalled in a reset cycle.
  assign req_ready = (rst_n && (state_q == ST_IDLE)) ? gnt : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          rsp_data_d  = sel_xor;
          rsp_id_d    = gnt_idx;
          rsp_valid_d = 1'b1;
          ptr_d       = IDW'(rr_next_idx(32'(gnt_idx), NREQ));
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef XOR_ARB_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if ((state_q == ST_IDLE) && any_valid) begin
      parity_d = ^sel_xor;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign rsp_parity = parity_q;
`endif

endmodule

// File: tb/tb_xor_share_arb.sv
module tb_xor_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
`ifdef XOR_ARB_PARITY_EN
  logic        rsp_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  xor_share_arb #(
    .WIDTH (8),
    .NREQ  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef XOR_ARB_PARITY_EN
    ,
    .rsp_parity(rsp_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin winner: first valid index scanning from p upward, modulo 4.
  function automatic int ref_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a     = $urandom;
    req_b     = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (req_ready !== 4'h0) begin
        n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
      end
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_valid: got %b expected 0", rsp_valid);
      end
      n_cmp++;
      if (rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
        n_err++; $display("FAIL reset_rsp: got data %h id %0d expected 00 / 0", rsp_data, rsp_id);
      end
    end
    req_valid = 4'h0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    // ptr is 0 after reset; requester 2 alone is valid.
    req_a = 32'h0;
    req_b = 32'h0;
    req_a[16 +: 8] = 8'hA5;
    req_b[16 +: 8] = 8'h0F;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hAA || rsp_id !== 2'd2) begin
      n_err++; $display("FAIL single_rsp: got v%b %h id%0d expected v1 aa id2", rsp_valid, rsp_data, rsp_id);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL single_hold_ready: got %b expected 0000", req_ready);
    end
`ifdef XOR_ARB_PARITY_EN
    n_cmp++;
    if (rsp_parity !== 1'b0) begin
      n_err++; $display("FAIL single_parity: got %b expected 0", rsp_parity);
    end
`endif
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: got %b expected 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [7:0] ea;
    logic [7:0] eb;
    rst_n = 1'b0;
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      n_cmp++;
      if (req_ready !== (4'b0001 << exp_order[n])) begin
        n_err++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'b0001 << exp_order[n]);
      end
      tick();
      ea = req_a[exp_order[n]*8 +: 8];
      eb = req_b[exp_order[n]*8 +: 8];
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_order[n]) || rsp_data !== (ea ^ eb)) begin
        n_err++; $display("FAIL rr_rsp%0d: got v%b id%0d %h expected v1 id%0d %h",
                          n, rsp_valid, rsp_id, rsp_data, exp_order[n], ea ^ eb);
      end
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL rr_hold%0d: got %b expected 0000", n, req_ready);
      end
      tick();
    end
    req_valid = 4'h0;
    // ptr now 1
  endtask

  task automatic test_backpressure();
    logic [7:0] e1;
    logic [7:0] e2;
    e1 = req_a[8 +: 8] ^ req_b[8 +: 8];
    e2 = req_a[16 +: 8] ^ req_b[16 +: 8];
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL bp_first: got %b expected 0010", req_ready);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== e1) begin
        n_err++; $display("FAIL bp_stable%0d: got v%b id%0d %h expected v1 id1 %h", c, rsp_valid, rsp_id, rsp_data, e1);
      end
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_ready%0d: got %b expected 0000", c, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL bp_hs_ready: got %b expected 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_next: got v%b ready %b expected v0 ready 0100", rsp_valid, req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== e2) begin
      n_err++; $display("FAIL bp_next_rsp: got v%b id%0d %h expected v1 id2 %h", rsp_valid, rsp_id, rsp_data, e2);
    end
    req_valid = 4'h0;
    tick();
    // ptr now 3
  endtask

  task automatic test_wrap_skip();
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL wrap_grant: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = 4'h0;
    n_cmp++;
    if (rsp_id !== 2'd1) begin
      n_err++; $display("FAIL wrap_id: got %0d expected 1", rsp_id);
    end
    tick();
    // ptr should be 2: with all requesting, 2 must win
    req_valid = 4'hF;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL wrap_ptr: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = 4'h0;
    tick();
    // ptr now 3
  endtask

  task automatic test_reset_mid_hold();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'h0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      n_err++; $display("FAIL mid_setup: got v%b id%0d expected v1 id1", rsp_valid, rsp_id);
    end
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_discard: got %b expected 0", rsp_valid);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = 4'h0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      n_err++; $display("FAIL mid_first_rsp: got v%b id%0d expected v1 id0", rsp_valid, rsp_id);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] pa[4];
    logic [7:0] pb[4];
    logic [3:0] pend;
    int         ptr;
    bit         hold;
    logic [7:0] exp_data;
    int         exp_id;
    int         w;
    logic [3:0] exp_ready;
    bit         rr;

    rst_n = 1'b0;
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    ptr  = 0;
    hold = 0;
    pend = 4'h0;
    exp_data = 8'h00;
    exp_id = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = 8'($urandom);
          pb[i] = 8'($urandom);
        end
        req_a[i*8 +: 8] = pend[i] ? pa[i] : 8'($urandom);
        req_b[i*8 +: 8] = pend[i] ? pb[i] : 8'($urandom);
      end
      req_valid = pend;
      rr = ($urandom_range(0, 3) != 0);
      rsp_ready = rr;
      #1;
      w = hold ? -1 : ref_pick(pend, ptr);
      exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_err++; $display("FAIL rand_ready c%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      tick();
      if (hold) begin
        if (rr) hold = 0;
      end else if (w >= 0) begin
        hold     = 1;
        exp_data = pa[w] ^ pb[w];
        exp_id   = w;
        ptr      = (w + 1) % 4;
        pend[w]  = 1'b0;
      end
      n_cmp++;
      if (rsp_valid !== hold) begin
        n_err++; $display("FAIL rand_valid c%0d: got %b expected %b", c, rsp_valid, hold);
      end
      if (hold) begin
        n_cmp++;
        if (rsp_data !== exp_data || rsp_id !== 2'(exp_id)) begin
          n_err++; $display("FAIL rand_rsp c%0d: got %h id%0d expected %h id%0d", c, rsp_data, rsp_id, exp_data, exp_id);
        end
`ifdef XOR_ARB_PARITY_EN
        n_cmp++;
        if (rsp_parity !== ^exp_data) begin
          n_err++; $display("FAIL rand_parity c%0d: got %b expected %b", c, rsp_parity, ^exp_data);
        end
`endif
      end
    end
    req_valid = 4'h0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
